// File: rtl/fixedpoint_expander.sv
// fixedpoint_expander
// -------------------
// This block takes in a word of NUM_LANES packed signed fixed-point elements.
// It emits one element per output handshake, lane 0 first. Each element is
// widened into the accumulator format: sign-extended, with 2*WIDTH_FRACTION
// fraction bits. The widening is exact, so the element can always be recovered
// from out_data_o[WIDTH_FRACTION +: WIDTH_ELEM].
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   in_valid_i   : input word valid
//   in_ready_o   : block can accept an input word
//   in_data_i    : packed elements, lane k at [k*WIDTH_ELEM +: WIDTH_ELEM]
//   in_last_i    : word is the last of a vector
//   out_valid_o  : expanded element valid
//   out_ready_i  : downstream accepts the element
//   out_data_o   : expanded element
//   out_last_o   : element is the highest lane of a last word
//   clear_i      : synchronous clear of sat_cnt_o
//   sat_cnt_o    : saturating count of emitted elements at the packed extremes
module fixedpoint_expander #(
  parameter int unsigned WIDTH_ELEM     = 16,
  parameter int unsigned NUM_LANES      = 2,
  parameter int unsigned WIDTH_OUTPUT   = 32,
  parameter int unsigned WIDTH_INTEGER  = 6,
  parameter int unsigned WIDTH_FRACTION = 9,
  parameter int unsigned WIDTH_CNT      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [NUM_LANES*WIDTH_ELEM-1:0] in_data_i,
  input  logic                            in_last_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WIDTH_OUTPUT-1:0]         out_data_o,
  output logic                            out_last_o,
  input  logic                            clear_i,
  output logic [WIDTH_CNT-1:0]            sat_cnt_o
);

  localparam int unsigned WIDTH_WORD = NUM_LANES * WIDTH_ELEM;
  localparam int unsigned WIDTH_LANE = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned WIDTH_EXT  = WIDTH_OUTPUT - WIDTH_ELEM;
  // Sign bit position of an element: it sits above the integer and fraction fields.
  localparam int unsigned SIGN_BIT   = WIDTH_INTEGER + WIDTH_FRACTION;

  localparam logic [WIDTH_LANE-1:0] LAST_LANE = WIDTH_LANE'(NUM_LANES - 1);
  localparam logic [WIDTH_ELEM-1:0] ELEM_MAX  = {1'b0, {(WIDTH_ELEM-1){1'b1}}};
  localparam logic [WIDTH_ELEM-1:0] ELEM_MIN  = {1'b1, {(WIDTH_ELEM-1){1'b0}}};
  localparam logic [WIDTH_CNT-1:0]  CNT_MAX   = {WIDTH_CNT{1'b1}};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [WIDTH_WORD-1:0]   word_q;
  logic                    last_q;
  logic [WIDTH_LANE-1:0]   lane_q;
  logic [WIDTH_CNT-1:0]    sat_cnt_q;

  logic                    lane_is_last;
  logic                    in_hs;
  logic                    out_hs;
  logic                    lane_inc;
  logic [WIDTH_ELEM-1:0]   cur_elem;
  logic                    cur_is_sat;
  logic [WIDTH_OUTPUT-1:0] cur_ext;

  assign lane_is_last = (lane_q == LAST_LANE);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A new word arriving with the last lane keeps the block in DRAIN.
        if (out_hs && lane_is_last && !in_hs) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake and control outputs
  always_comb begin
    out_valid_o = 1'b0;
    in_ready_o  = 1'b0;
    in_hs       = 1'b0;
    out_hs      = 1'b0;
    lane_inc    = 1'b0;
    out_valid_o = (state_q == ST_DRAIN);
    // Accepting on the final lane's handshake gives one element per cycle with no bubbles.
    in_ready_o  = (state_q == ST_EMPTY) || (lane_is_last && out_ready_i);
    in_hs       = in_valid_i && in_ready_o;
    out_hs      = out_valid_o && out_ready_i;
    lane_inc    = out_hs && !lane_is_last;
  end

  // Held word, last flag and lane index
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      last_q <= 1'b0;
      lane_q <= '0;
    end else if (in_hs) begin
      word_q <= in_data_i;
      last_q <= in_last_i;
      lane_q <= '0;
    end else if (lane_inc) begin
      lane_q <= lane_q + WIDTH_LANE'(1);
    end
  end

  // Select the element for the current lane
  always_comb begin
    cur_elem = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_q == WIDTH_LANE'(k)) cur_elem = word_q[k*WIDTH_ELEM +: WIDTH_ELEM];
    end
  end

  // Exact widening: sign-extend, then move the binary point up by WIDTH_FRACTION
  always_comb begin
    cur_ext    = {{WIDTH_EXT{cur_elem[SIGN_BIT]}}, cur_elem};
    out_data_o = cur_ext << WIDTH_FRACTION;
    cur_is_sat = (cur_elem == ELEM_MAX) || (cur_elem == ELEM_MIN);
  end

  assign out_last_o = last_q && lane_is_last;

  // Extreme-value counter; clear has priority over a coincident increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else if (clear_i) begin
      sat_cnt_q <= '0;
    end else if (out_hs && cur_is_sat && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_q <= sat_cnt_q + WIDTH_CNT'(1);
    end
  end

  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_fixedpoint_expander.sv
// Testbench for fixedpoint_expander. A negedge scoreboard predicts every
// output element, the handshake signals and the extreme-value counter.
// Directed sequences also check the literal values for the key cases.
module tb_fixedpoint_expander;

  localparam int unsigned WE = 16;
  localparam int unsigned NL = 2;
  localparam int unsigned WO = 32;
  localparam int unsigned WF = 9;
  localparam int unsigned WC = 16;

  logic          clk_i       = 1'b0;
  logic          rst_i       = 1'b1;
  logic          in_valid_i  = 1'b0;
  logic          in_last_i   = 1'b0;
  logic          out_ready_i = 1'b0;
  logic          clear_i     = 1'b0;
  logic [NL*WE-1:0] in_data_i = '0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic          out_last_o;
  logic [WO-1:0] out_data_o;
  logic [WC-1:0] sat_cnt_o;

  fixedpoint_expander #(
    .WIDTH_ELEM(WE), .NUM_LANES(NL), .WIDTH_OUTPUT(WO),
    .WIDTH_INTEGER(6), .WIDTH_FRACTION(WF), .WIDTH_CNT(WC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .clear_i(clear_i), .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [WO-1:0] data;
    logic [WE-1:0] elem;
    logic          last;
    logic          sat;
  } exp_t;

  exp_t          sb_q[$];
  logic [WC-1:0] sat_m = '0;
  int            checks = 0;
  int            errors = 0;
  logic          rand_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference widening: the signed value scaled by 2**WF
  function automatic logic [WO-1:0] expand(input logic [WE-1:0] e);
    int v;
    v = int'($signed(e));
    return WO'(v * (1 << WF));
  endfunction

  // Scoreboard: compare the current outputs, then advance the model to the next edge
  always @(negedge clk_i) begin : monitor
    logic exp_valid;
    logic exp_ready;
    exp_t e;
    logic [WE-1:0] el;
    if (rst_i) begin
      sb_q.delete();
      sat_m = '0;
      check_eq("rst_valid", 64'(out_valid_o), 64'd0);
      check_eq("rst_ready", 64'(in_ready_o), 64'd1);
      check_eq("rst_last",  64'(out_last_o), 64'd0);
      check_eq("rst_data",  64'(out_data_o), 64'd0);
      check_eq("rst_sat",   64'(sat_cnt_o), 64'd0);
    end else begin
      exp_valid = (sb_q.size() != 0);
      exp_ready = (sb_q.size() == 0) || ((sb_q.size() == 1) && out_ready_i);
      check_eq("out_valid", 64'(out_valid_o), 64'(exp_valid));
      check_eq("in_ready",  64'(in_ready_o),  64'(exp_ready));
      check_eq("sat_cnt",   64'(sat_cnt_o),   64'(sat_m));
      if (exp_valid) begin
        check_eq("out_data",  64'(out_data_o), 64'(sb_q[0].data));
        check_eq("out_last",  64'(out_last_o), 64'(sb_q[0].last));
        check_eq("roundtrip", 64'(out_data_o[WF +: WE]), 64'(sb_q[0].elem));
      end
      if (exp_valid && out_ready_i) begin
        e = sb_q.pop_front();
        if (clear_i) sat_m = '0;
        else if (e.sat && (sat_m != '1)) sat_m = sat_m + WC'(1);
      end else if (clear_i) begin
        sat_m = '0;
      end
      if (in_valid_i && exp_ready) begin
        for (int k = 0; k < NL; k++) begin
          el     = in_data_i[k*WE +: WE];
          e.elem = el;
          e.data = expand(el);
          e.last = in_last_i && (k == NL - 1);
          e.sat  = (el == 16'h7FFF) || (el == 16'h8000);
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Offer a word until accepted; returns #1 after the accepting edge
  task automatic send(input logic [NL*WE-1:0] w, input logic l);
    int   budget;
    logic hs;
    budget     = 0;
    in_valid_i = 1'b1;
    in_data_i  = w;
    in_last_i  = l;
    do begin
      @(negedge clk_i);
      hs = in_ready_o;
      @(posedge clk_i);
      #1;
      budget++;
    end while (!hs && budget < 500);
    if (!hs) check_eq("send_timeout", 64'(hs), 64'd1);
    in_valid_i = 1'b0;
  endtask

  function automatic logic [WE-1:0] rand_elem();
    int unsigned p;
    p = $urandom_range(0, 7);
    if (p == 0) return 16'h7FFF;
    if (p == 1) return 16'h8000;
    return WE'($urandom);
  endfunction

  logic [WO-1:0] held;

  initial begin
    cycles(3);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rel_valid", 64'(out_valid_o), 64'd0);
    check_eq("rel_ready", 64'(in_ready_o), 64'd1);
    check_eq("rel_sat",   64'(sat_cnt_o), 64'd0);
    cycles(1);

    // Basic expansion, one cycle latency
    out_ready_i = 1'b1;
    send(32'hFE00_0200, 1'b0);
    check_eq("s2_lane0", 64'(out_data_o), 64'h0004_0000);
    cycles(1);
    check_eq("s2_lane1", 64'(out_data_o), 64'hFFFC_0000);
    cycles(1);
    check_eq("s2_idle", 64'(out_valid_o), 64'd0);

    // Back-to-back words stream without bubbles
    send(32'h0001_0002, 1'b0);
    send(32'h0003_0004, 1'b1);
    check_eq("s3_w2_lane0", 64'(out_data_o), 64'(expand(16'h0004)));
    cycles(3);

    // Stall on lane 0
    out_ready_i = 1'b0;
    send(32'h1234_5678, 1'b0);
    held = out_data_o;
    check_eq("s4_lane0", 64'(held), 64'h00AC_F000);
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      check_eq("s4_stable", 64'(out_data_o), 64'(held));
      check_eq("s4_noready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    cycles(1);
    check_eq("s4_lane1", 64'(out_data_o), 64'h0024_6800);
    cycles(2);

    // Extremes, last flag, counter and clear priority
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    send(32'h8000_7FFF, 1'b1);
    check_eq("s5_lane0", 64'(out_data_o), 64'h00FF_FE00);
    check_eq("s5_last0", 64'(out_last_o), 64'd0);
    cycles(1);
    check_eq("s5_lane1", 64'(out_data_o), 64'hFF00_0000);
    check_eq("s5_last1", 64'(out_last_o), 64'd1);
    cycles(1);
    check_eq("s5_sat2", 64'(sat_cnt_o), 64'd2);
    send(32'h0000_7FFF, 1'b0);
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    check_eq("s5_clear", 64'(sat_cnt_o), 64'd0);
    cycles(2);
    check_eq("s5_clear_hold", 64'(sat_cnt_o), 64'd0);

    // Reset in the middle of a word
    out_ready_i = 1'b0;
    send(32'h1111_2222, 1'b0);
    check_eq("s6_valid_pre", 64'(out_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check_eq("s6_valid_rst", 64'(out_valid_o), 64'd0);
    cycles(1);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check_eq("s6_no_lane1", 64'(out_valid_o), 64'd0);
    end

    // Random traffic with random backpressure
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          cycles(int'($urandom_range(0, 2)));
          send({rand_elem(), rand_elem()}, 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready_i = ($urandom_range(0, 3) != 0);
          cycles(1);
        end
        out_ready_i = 1'b1;
      end
    join

    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      cycles(1);
    end
    check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
